// File: rtl/traffic_light_controller_param.sv
`default_nettype none
// ============================================================================
// traffic_light_controller_param: highway/local-road controller with timed
// phases, local green extension, pedestrian walk and night flashing. Rev 1.0
// ============================================================================
module traffic_light_controller_param #(
   parameter int HW_GREEN_MIN = 25,
   parameter int LR_GREEN_MIN = 10,
   parameter int LR_GREEN_MAX = 25,
   parameter int YELLOW_LEN   = 5,
   parameter int ALL_RED_LEN  = 1,
   parameter int FLASH_HALF   = 4,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lr_has_car,
   input  logic       ped_req,
   input  logic       night_mode,
   output logic [2:0] hw_light,
   output logic [2:0] lr_light,
   output logic       ped_walk,
   output logic [3:0] state
);

   localparam logic [3:0] c_IDLE    = 4'd0;
   localparam logic [3:0] c_HW_MIN  = 4'd1;
   localparam logic [3:0] c_HW_FREE = 4'd2;
   localparam logic [3:0] c_HW_YEL  = 4'd3;
   localparam logic [3:0] c_AR_1    = 4'd4;
   localparam logic [3:0] c_LR_GRN  = 4'd5;
   localparam logic [3:0] c_LR_YEL  = 4'd6;
   localparam logic [3:0] c_AR_2    = 4'd7;
   localparam logic [3:0] c_FLASH   = 4'd8;

   localparam logic [2:0] c_OFF = 3'b000;
   localparam logic [2:0] c_GRN = 3'b001;
   localparam logic [2:0] c_YEL = 3'b010;
   localparam logic [2:0] c_RED = 3'b100;

   localparam logic [CNT_W-1:0] c_HWG_LAST   = CNT_W'(HW_GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] c_LRMIN_LAST = CNT_W'(LR_GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] c_LRMAX_LAST = CNT_W'(LR_GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] c_YEL_LAST   = CNT_W'(YELLOW_LEN - 1);
   localparam logic [CNT_W-1:0] c_AR_LAST    = CNT_W'(ALL_RED_LEN - 1);
   localparam logic [CNT_W-1:0] c_FL_LAST    = CNT_W'(FLASH_HALF - 1);

   logic [3:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_hw;
   logic [2:0]       r_lr;
   logic             r_walk;
   logic             r_ped;
   logic             r_flash_on;

   logic [3:0]       w_nstate;
   logic             w_entry;
   logic             w_flash_wrap;
   logic             w_flash_on_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       w_hw_nxt;
   logic [2:0]       w_lr_nxt;
   logic             w_walk_nxt;
   logic             w_ped_nxt;

   always_comb begin
      w_nstate = r_state;
      case (r_state)
         c_IDLE:    w_nstate = night_mode ? c_FLASH : c_HW_MIN;
         c_HW_MIN:  if (r_cnt == c_HWG_LAST)
                       w_nstate = (lr_has_car || r_ped) ? c_HW_YEL : c_HW_FREE;
         c_HW_FREE: if (night_mode)               w_nstate = c_FLASH;
                    else if (lr_has_car || r_ped) w_nstate = c_HW_YEL;
         c_HW_YEL:  if (r_cnt == c_YEL_LAST) w_nstate = c_AR_1;
         c_AR_1:    if (r_cnt == c_AR_LAST)  w_nstate = c_LR_GRN;
         // Extension ends as soon as the road is empty past the minimum, or at the hard cap.
         c_LR_GRN:  if (((r_cnt >= c_LRMIN_LAST) && !lr_has_car) || (r_cnt == c_LRMAX_LAST))
                       w_nstate = c_LR_YEL;
         c_LR_YEL:  if (r_cnt == c_YEL_LAST) w_nstate = c_AR_2;
         c_AR_2:    if (r_cnt == c_AR_LAST)  w_nstate = c_HW_MIN;
         c_FLASH:   if (!night_mode)         w_nstate = c_AR_2;
         default:   w_nstate = c_IDLE;
      endcase
   end

   always_comb begin
      w_entry        = (w_nstate != r_state);
      w_flash_wrap   = (r_state == c_FLASH) && (r_cnt == c_FL_LAST);
      w_flash_on_nxt = w_entry ? 1'b1 : (w_flash_wrap ? ~r_flash_on : r_flash_on);

      if (w_entry || w_flash_wrap)
         w_cnt_nxt = '0;
      else if (r_state == c_HW_FREE)
         w_cnt_nxt = r_cnt;
      else
         w_cnt_nxt = r_cnt + 1'b1;

      w_hw_nxt = c_OFF;
      w_lr_nxt = c_OFF;
      case (w_nstate)
         c_HW_MIN, c_HW_FREE: begin w_hw_nxt = c_GRN; w_lr_nxt = c_RED; end
         c_HW_YEL:            begin w_hw_nxt = c_YEL; w_lr_nxt = c_RED; end
         c_AR_1, c_AR_2:      begin w_hw_nxt = c_RED; w_lr_nxt = c_RED; end
         c_LR_GRN:            begin w_hw_nxt = c_RED; w_lr_nxt = c_GRN; end
         c_LR_YEL:            begin w_hw_nxt = c_RED; w_lr_nxt = c_YEL; end
         c_FLASH:             if (w_flash_on_nxt) begin w_hw_nxt = c_YEL; w_lr_nxt = c_RED; end
         default:             ;
      endcase

      // Walk is granted from the request latched before LR_GREEN, held for the whole green.
      if (w_nstate == c_LR_GRN)
         w_walk_nxt = (r_state == c_LR_GRN) ? r_walk : r_ped;
      else
         w_walk_nxt = 1'b0;

      if (w_entry && (w_nstate == c_LR_GRN))
         w_ped_nxt = 1'b0;
      else if (ped_req && (r_state != c_LR_GRN))
         w_ped_nxt = 1'b1;
      else
         w_ped_nxt = r_ped;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_IDLE;
         r_cnt      <= '0;
         r_hw       <= c_OFF;
         r_lr       <= c_OFF;
         r_walk     <= 1'b0;
         r_ped      <= 1'b0;
         r_flash_on <= 1'b0;
      end else begin
         r_state    <= w_nstate;
         r_cnt      <= w_cnt_nxt;
         r_hw       <= w_hw_nxt;
         r_lr       <= w_lr_nxt;
         r_walk     <= w_walk_nxt;
         r_ped      <= w_ped_nxt;
         r_flash_on <= w_flash_on_nxt;
      end
   end

   assign state    = r_state;
   assign hw_light = r_hw;
   assign lr_light = r_lr;
   assign ped_walk = r_walk;

   a_no_conflict: assert property (@(posedge clk) disable iff (rst)
      !((hw_light[1:0] != 2'b00) && (lr_light[1:0] != 2'b00)));

endmodule

`default_nettype wire

// File: doc/traffic_light_controller_param.md
Name: traffic_light_controller_param

Overview:
- Parametrised successor to the two-road (highway / local road) traffic light controller.
- Adds configurable phase durations and an all-red clearance interval of programmable length.
- Adds local-road green extension driven by the car sensor, bounded by a maximum.
- Adds a latched pedestrian request with a walk output, and a night flashing mode entered and left only at safe points.
- Sits between the road sensors/switches and the lamp drivers.

Parameters:
- HW_GREEN_MIN, 25, highway guaranteed green length in cycles (>=1)
- LR_GREEN_MIN, 10, local-road minimum green in cycles (>=1)
- LR_GREEN_MAX, 25, local-road maximum green in cycles (>=LR_GREEN_MIN)
- YELLOW_LEN, 5, yellow length in cycles, both roads (>=1)
- ALL_RED_LEN, 1, all-red clearance in cycles (>=1)
- FLASH_HALF, 4, cycles per on/off half-period in night mode (>=1)
- CNT_W, 8, phase counter width; must hold max(all lengths)-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- lr_has_car  in  1  local-road car sensor, level
- ped_req  in  1  pedestrian button; a 1-cycle pulse suffices
- night_mode  in  1  level request for flashing mode
- hw_light  out  3  highway lamps: 001 green, 010 yellow, 100 red, 000 off
- lr_light  out  3  local-road lamps, same encoding
- ped_walk  out  1  pedestrian walk lamp
- state  out  4  current state encoding

Behaviour:
- All outputs are registered and change only on a clk rising edge or on rst.
- Reset (async): state=IDLE, hw_light=000, lr_light=000, ped_walk=0, counter=0, ped_pending=0.
- State encodings: IDLE=0, HW_GREEN_MIN=1, HW_GREEN_FREE=2, HW_YELLOW=3, ALL_RED_1=4, LR_GREEN=5, LR_YELLOW=6, ALL_RED_2=7, FLASH=8. Codes 9-15 recover to IDLE on the next cycle.
- Counter: cleared on every state entry, increments each cycle in a timed state. A phase of length N occupies exactly N cycles (counter 0..N-1).
- ped_pending:
  - set by ped_req in any state except LR_GREEN;
  - cleared on entry to LR_GREEN;
  - ped_req and the clear in the same cycle -> clear wins.
- IDLE: next cycle -> FLASH if night_mode, else HW_GREEN_MIN (hw=001, lr=100).
- HW_GREEN_MIN: at counter==HW_GREEN_MIN-1:
  - -> HW_YELLOW (hw=010) if lr_has_car or ped_pending;
  - else -> HW_GREEN_FREE.
- HW_GREEN_FREE: each cycle, priority order:
  - night_mode -> FLASH;
  - else lr_has_car or ped_pending -> HW_YELLOW (hw=010);
  - else stay.
- HW_YELLOW: YELLOW_LEN cycles -> ALL_RED_1 (hw=100).
- ALL_RED_1: ALL_RED_LEN cycles -> LR_GREEN (lr=001). ped_walk=1 if ped_pending was set at that transition.
- LR_GREEN: exit -> LR_YELLOW (lr=010, ped_walk=0) when either:
  - counter>=LR_GREEN_MIN-1 and !lr_has_car; or
  - counter==LR_GREEN_MAX-1, regardless of the sensor.
- LR_YELLOW: YELLOW_LEN cycles -> ALL_RED_2 (lr=100).
- ALL_RED_2: ALL_RED_LEN cycles -> HW_GREEN_MIN (hw=001).
- night_mode is ignored in every state except IDLE, HW_GREEN_FREE and FLASH.
- FLASH:
  - Entry sets hw=010, lr=100 (on phase).
  - Every FLASH_HALF cycles, both lights toggle together between on (010/100) and off (000/000).
  - ped_walk=0 throughout.
  - When night_mode=0 -> ALL_RED_2 (hw=100, lr=100), then the normal sequence resumes.
- Lights are never green or yellow on both roads simultaneously. This must hold as an assertion.
- Reset asserted mid-phase returns everything to reset values immediately. Operation restarts with IDLE on the first edge after deassertion.

Test Plan:
- Reset, lr_has_car=0, night_mode=0 -> IDLE 1 cycle, then hw=001 for 25 cycles, state 1 -> 2, stays in 2 indefinitely with lr=100.
- Assert lr_has_car at HW_GREEN_MIN counter 10 and hold -> hw green 25 cycles total, 5 yellow, 1 all-red. Local green runs to the 25-cycle maximum, then lr 5 yellow, 1 all-red, then back to HW_GREEN_MIN.
- Single lr_has_car pulse in HW_GREEN_FREE -> local green lasts exactly LR_GREEN_MIN=10 cycles.
- 1-cycle ped_req pulse with no car -> ped_walk=1 for exactly the LR_GREEN duration (10 cycles); ped_pending cleared. Second pulse during LR_GREEN is ignored.
- night_mode=1 during HW_GREEN_MIN -> no effect until HW_GREEN_FREE, then FLASH: hw/lr toggle 010,100 / 000,000 every 4 cycles. Drop night_mode -> ALL_RED_2 (100/100) 1 cycle -> HW_GREEN_MIN.
- Assert rst asynchronously mid-LR_YELLOW -> outputs go to 000/000/0, state=0 without waiting for a clock edge.
